// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, operands shifted LSB-first,
// carry held in a flop, parallel sum/cout committed with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, nxt;

    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_full;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fs, fc;
    logic             accept, last;

    assign fs       = opa[0] ^ opb[0] ^ carry;
    assign fc       = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    assign last     = (cnt == CW'(WIDTH - 1));
    // res holds bits 0..WIDTH-2 once the slice produces the final bit
    assign res_full = {fs, res};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt    = state;
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            res   <= res_full[WIDTH-1:1];
            carry <= fc;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res_full;
                cout <= fc;
            end
        end
    end

endmodule
